mem_arb: RTL and testbench

Arbiter that shares one memory access port between instruction fetch (IF) and load/store (LS). It sits between the fetch unit, the load/store stage and the unified RAM. It grants one requester per cycle, routes read data back to its owner one cycle later, and raises a fetch-pause request toward ctrl whenever IF is refused.

---
 rtl/mem_arb.sv | 115 +++++++++++
 tb/tb_mem_arb.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Define MEM_ARB_STARVE_GUARD_EN to bound how long IF can be starved by LS.
module mem_arb #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_pause,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [XLEN-1:0] ls_addr,
    input  logic [XLEN-1:0] ls_wdata,
    output logic            ls_gnt,
    output logic            ls_rvalid,
    output logic [XLEN-1:0] ls_rdata,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

    owner_e owner_q, owner_d;
    logic   force_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q, starve_cnt_d;

    assign force_if = (starve_cnt_q == LIMIT);

    // Counts contested LS wins; any cycle IF is idle or served resets it.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req || if_gnt) begin
            starve_cnt_d = 4'd0;
        end else if (ls_gnt && (starve_cnt_q != LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    // Outputs are gated by rst so everything reads 0 while held in reset.
    assign if_gnt   = rst & if_req & (~ls_req | force_if);
    assign ls_gnt   = rst & ls_req & ~if_gnt;
    assign if_pause = rst & if_req & ~if_gnt;

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        unique case (1'b1)
            if_gnt: begin
                mem_addr = if_addr;
            end
            ls_gnt: begin
                mem_addr  = ls_addr;
                mem_we    = ls_we;
                mem_wdata = ls_we ? ls_wdata : '0;
            end
            default: begin
                mem_addr = '0;
            end
        endcase
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (if_gnt) begin
            owner_d = OWN_IF;
        end else if (ls_gnt && !ls_we) begin
            owner_d = OWN_LS;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    assign if_rvalid = rst & (owner_q == OWN_IF);
    assign ls_rvalid = rst & (owner_q == OWN_LS);
    assign if_rdata  = rst ? mem_rdata : '0;
    assign ls_rdata  = rst ? mem_rdata : '0;

    a_one_gnt: assert property (@(posedge clk) !(if_gnt && ls_gnt));
    a_limit: assert property (@(posedge clk)
        (STARVE_LIMIT >= 1) && (STARVE_LIMIT <= 15));

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with a behavioural arbiter/RAM model.
// Build with MEM_ARB_STARVE_GUARD_EN to check the starvation guard.
module tb_mem_arb;

    localparam int XLEN  = 32;
    localparam int LIMIT = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_req, ls_req, ls_we;
    logic [XLEN-1:0] if_addr, ls_addr, ls_wdata;
    logic            if_gnt, if_rvalid, if_pause;
    logic            ls_gnt, ls_rvalid;
    logic [XLEN-1:0] if_rdata, ls_rdata;
    logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
    logic            mem_we;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram [256];
    logic [31:0] sh  [256];

    bit          pend_v;
    int          pend_own;
    logic [31:0] pend_data;
    int          streak;
    logic [9:0]  pat;

    mem_arb #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_pause  (if_pause),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Registered-read RAM; a write lands at the clock edge ending its cycle.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[9:2]];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Model: decide the winner from the arbitration rules, track pending
    // read data from a shadow copy of memory, compare every cycle.
    always @(negedge clk) begin
        bit          g_if, g_ls, frc, e_ifv, e_lsv;
        logic [31:0] e_addr, e_wdata;
        bit          e_we;
        if (!rst) begin
            chk("rst_if_gnt", {31'b0, if_gnt}, 0);
            chk("rst_ls_gnt", {31'b0, ls_gnt}, 0);
            chk("rst_if_rvalid", {31'b0, if_rvalid}, 0);
            chk("rst_ls_rvalid", {31'b0, ls_rvalid}, 0);
            chk("rst_pause", {31'b0, if_pause}, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_we", {31'b0, mem_we}, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            pend_v <= 1'b0;
            streak <= 0;
        end else begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            frc = if_req && ls_req && (streak == LIMIT);
`else
            frc = 1'b0;
`endif
            g_if = if_req && (!ls_req || frc);
            g_ls = ls_req && !g_if;
            e_addr  = g_if ? if_addr : (g_ls ? ls_addr : 32'h0);
            e_we    = g_ls && ls_we;
            e_wdata = e_we ? ls_wdata : 32'h0;
            e_ifv = pend_v && (pend_own == 1);
            e_lsv = pend_v && (pend_own == 2);
            chk("if_gnt", {31'b0, if_gnt}, {31'b0, g_if});
            chk("ls_gnt", {31'b0, ls_gnt}, {31'b0, g_ls});
            chk("if_pause", {31'b0, if_pause}, {31'b0, if_req && !g_if});
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
            chk("mem_wdata", mem_wdata, e_wdata);
            chk("if_rvalid", {31'b0, if_rvalid}, {31'b0, e_ifv});
            chk("ls_rvalid", {31'b0, ls_rvalid}, {31'b0, e_lsv});
            if (e_ifv) chk("if_rdata", if_rdata, pend_data);
            if (e_lsv) chk("ls_rdata", ls_rdata, pend_data);
            pend_v <= g_if || (g_ls && !ls_we);
            pend_own <= g_if ? 1 : 2;
            pend_data <= g_if ? sh[if_addr[9:2]] : sh[ls_addr[9:2]];
            if (g_ls && ls_we) sh[ls_addr[9:2]] <= ls_wdata;
            if (!if_req || g_if) streak <= 0;
            else if (g_ls && streak < LIMIT) streak <= streak + 1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i] = 32'hA500_0000 + i;
            sh[i]  = 32'hA500_0000 + i;
        end
        pend_v = 1'b0; pend_own = 0; pend_data = '0; streak = 0;
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h80;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h40; ls_wdata = '0;

        // Reset held with both requesting
        repeat (3) @(negedge clk);
        chk("lit_rst_gnt", {30'b0, if_gnt, ls_gnt}, 0);
        cyc(); rst = 1'b1;
        @(negedge clk);
        chk("lit_first_ls", {30'b0, if_gnt, ls_gnt}, 32'h1);
        chk("lit_first_pause", {31'b0, if_pause}, 1);
        cyc(); ls_req = 1'b0;
        @(negedge clk);
        chk("lit_ls_rdata_40", ls_rdata, 32'hA500_0010);
        cyc(); if_req = 1'b0;
        @(negedge clk);
        chk("lit_if_rdata_80", if_rdata, 32'hA500_0020);

        // IF alone, three consecutive fetches
        for (int i = 0; i < 3; i++) begin
            cyc(); if_req = 1'b1; if_addr = 32'(4 * i);
            @(negedge clk);
            chk("lit_if_alone_gnt", {31'b0, if_gnt}, 1);
            chk("lit_if_alone_pause", {31'b0, if_pause}, 0);
            if (i > 0) chk("lit_if_alone_rdata", if_rdata,
                           32'hA500_0000 + 32'(i - 1));
        end
        cyc(); if_req = 1'b0;
        @(negedge clk);
        chk("lit_if_alone_last", if_rdata, 32'hA500_0002);

        // Conflict: LS read wins, IF follows
        cyc(); if_req = 1'b1; if_addr = 32'hC;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h100;
        @(negedge clk);
        chk("lit_conf_ls_gnt", {31'b0, ls_gnt}, 1);
        chk("lit_conf_pause", {31'b0, if_pause}, 1);
        cyc(); ls_req = 1'b0;
        @(negedge clk);
        chk("lit_conf_if_gnt", {31'b0, if_gnt}, 1);
        chk("lit_conf_ls_rdata", ls_rdata, 32'hA500_0040);
        cyc(); if_req = 1'b0;
        @(negedge clk);
        chk("lit_conf_if_rdata", if_rdata, 32'hA500_0003);

        // Write then read the same address
        cyc(); ls_req = 1'b1; ls_we = 1'b1;
        ls_addr = 32'h200; ls_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("lit_wr_we", {31'b0, mem_we}, 1);
        cyc(); ls_we = 1'b0; ls_wdata = '0;
        @(negedge clk);
        chk("lit_wr_no_rvalid", {31'b0, ls_rvalid}, 0);
        chk("lit_rd_we_low", {31'b0, mem_we}, 0);
        cyc(); ls_req = 1'b0;
        @(negedge clk);
        chk("lit_rd_after_wr", ls_rdata, 32'hDEAD_BEEF);

        // Continuous contention for 10 cycles
        cyc(); if_req = 1'b1; if_addr = 32'h20;
        ls_req = 1'b1; ls_addr = 32'h10;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) cyc();
            @(negedge clk);
            pat[i] = if_gnt;
        end
`ifdef MEM_ARB_STARVE_GUARD_EN
        chk("lit_starve_pattern", {22'b0, pat}, 32'b10_0001_0000);
`else
        chk("lit_starve_pattern", {22'b0, pat}, 32'b0);
`endif
        cyc(); if_req = 1'b0; ls_req = 1'b0;
        repeat (2) @(negedge clk);

        // Reset falls while an IF response is in flight
        cyc(); if_req = 1'b1; if_addr = 32'h14;
        @(negedge clk);
        chk("lit_mid_gnt", {31'b0, if_gnt}, 1);
        cyc(); if_req = 1'b0;
        chk("lit_mid_rvalid_pre", {31'b0, if_rvalid}, 1);
        #1 rst = 1'b0;
        #1 chk("lit_mid_rvalid_rst", {31'b0, if_rvalid}, 0);
        repeat (2) @(negedge clk);
        cyc(); rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lit_mid_no_resp", {31'b0, if_rvalid}, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks,
                 errors);
        $finish;
    end

endmodule
